jt900h_cr: RTL and testbench
============================

# jt900h_cr

Control-register responder for the TLCS-900H core: owns the micro-DMA register bank (DMAS0-3, DMAD0-3, DMAC0-3, DMAM0-3) and INTNEST, and answers the CPU's control-register bus (`cra`/`crin`/`crwe` → `crout`). It also holds the four micro-DMA start vectors. It latches matching interrupt triggers as pending requests and arbitrates them into a single channel number `dmach` handed to the CPU microcode. It sits beside the CPU register file, between it and the interrupt controller.

## Interface
No parameters.

- `rst` input 1 — reset. Synchronous, active-high.
- `clk` input 1 — the single clock.
- `cen` input 1 — clock enable. All state advances only when `cen`=1.
- `cra` input 8 — control-register byte address.
- `crin` input 32 — write data.
- `crwe` input 1 — write strobe, one `cen` cycle.
- `crout` output 32 — registered read data.
- `dma_done` input 1 — terminal-count pulse for channel `dmach`.
- `dma_ack` input 1 — CPU accepted the request on `dmach`.
- `dma_rel` input 1 — CPU finished one transfer on `dmach`.
- `dma_req` output 1 — a channel is requesting service.
- `dmach` output 2 — channel being requested or serviced.
- `dma_end` output 4 — one-cycle end-of-transfer interrupt strobe per channel.
- `int_stb` input 1 — interrupt source fired.
- `int_vec` input 8 — vector of the source that fired.
- `vec_we` input 1 — start-vector write strobe (I/O bus).
- `vec_sel` input 2 — channel addressed by the start-vector write.
- `vec_din` input 8 — start-vector write data.

## Operation
- **Address map** (`cra`):
  - 0x00/04/08/0C: DMAS0-3, 32 bit.
  - 0x10/14/18/1C: DMAD0-3, 32 bit.
  - 0x20/24/28/2C: DMAC0-3, 16 bit.
  - 0x22/26/2A/2E: DMAM0-3, 8 bit.
  - 0x3C: INTNEST, 16 bit.
- **Writes**: on `crwe`, register width is set by the address. Upper `crin` bits are ignored; unmapped addresses are ignored.
- **Reads**: `crout` is zero-extended register contents. Unmapped addresses read 0.
- **Start vectors**: `vec_we` loads `vec[vec_sel]` <= `vec_din` and clears `pend[vec_sel]`.
- **Triggers**: `int_stb` with `int_vec`≠0 sets `pend[i]` for every channel with `vec[i]==int_vec`. Vector 0 never matches.
- **FSM**, states IDLE, REQ, SERV:
  - IDLE → REQ when `pend`≠0. Latch `dmach` = lowest set index; assert `dma_req`.
  - REQ → SERV on `dma_ack`. Clear `pend[dmach]`; deassert `dma_req`.
  - REQ → IDLE if `pend[dmach]` is cleared by a vector write.
  - SERV → IDLE on `dma_rel` or `dma_done`.
  - `dmach` is frozen in REQ and SERV.
- **`dma_done`**:
  - Clears `vec[dmach]` and `pend[dmach]`.
  - Pulses `dma_end[dmach]` the next cycle.
  - Takes effect in any state.
- **Collisions**:
  - `int_stb` match and `dma_ack` on the same channel in the same cycle: `pend` stays set.
  - `dma_done` and `int_stb` match on the same channel: `dma_done` wins (pend=0, vec=0).
  - `vec_we` and `dma_done` on the same channel: `vec_we` data wins; `pend`=0.
- **Reset values**:
  - All DMA registers and INTNEST = 0; `vec` = 0; `pend` = 0.
  - FSM = IDLE.
  - `crout` = 0, `dma_req` = 0, `dmach` = 0, `dma_end` = 0.
  - Reset mid-service aborts silently, with no `dma_end` pulse.

## Timing
- **Writes** commit at the `cen` edge where `crwe`=1.
- **`crout` latency**:
  - Reflects `cra` one `cen` cycle after `cra` is presented.
  - A read of a just-written register shows new data in the cycle after the write edge. No bypass.
- **Triggers**: `pend` sets one cycle after `int_stb`. `dma_req` rises one cycle later still (IDLE→REQ).
- **Ack**: `dma_req` falls the cycle after `dma_ack`.
- **Back-to-back service**: minimum IDLE dwell is one cycle between SERV exit and the next REQ.
- **`dma_end`** is exactly one `cen` cycle wide, one cycle after `dma_done`.
- **`cen`=0**: all outputs hold; strobes are not lost or repeated.

## Test plan
- **Map and reset**:
  - Stimulus: reset, then read every mapped and unmapped `cra`.
  - Expected: `crout`=0 throughout.
  - Write 0xDEADBEEF to 0x04, 0x20, 0x22, 0x3C.
  - Expected readback: 0xDEADBEEF, 0x0000BEEF, 0x000000EF, 0x0000BEEF; all other registers unchanged.
- **Trigger and arbitration**:
  - Stimulus: `vec[1]`=0x0A, `vec[3]`=0x0A; pulse `int_stb`, `int_vec`=0x0A.
  - Expected: `dma_req`=1 with `dmach`=1.
  - `dma_ack`, then `dma_rel`: next `dma_req` has `dmach`=3.
- **Terminal count**:
  - Stimulus: channel 2 in SERV; pulse `dma_done`.
  - Expected: `dma_end`=4'b0100 for one cycle; `vec[2]`=0; FSM returns to IDLE.
  - A later `int_vec`=old value raises no request.
- **Collisions**:
  - `int_stb` match on channel 0 in the same cycle as `dma_ack` for channel 0 → channel 0 is requested again after `dma_rel`.
  - `dma_done` together with a match on the same channel → no new request.
- **Vector cancel**:
  - Stimulus: channel 1 in REQ; `vec_we` to channel 1.
  - Expected: `dma_req` drops next cycle, FSM returns to IDLE; the new vector is stored.
- **`cen` gating and reset mid-service**:
  - `cen` toggling 1/0 gives identical results to the cases above, only stretched.
  - `rst` asserted in SERV → all outputs 0; no `dma_end` pulse.

Source files
------------

// File: rtl/jt900h_cr.sv
// rtl/jt900h_cr.sv - TLCS-900H control-register bank and micro-DMA request arbiter
//
// Holds DMAS/DMAD/DMAC/DMAM for four channels, INTNEST and the four micro-DMA
// start vectors. Turns matching interrupt triggers into pending requests and
// presents one channel at a time to the CPU microcode.
//
// Ports:
//   clk, rst, cen         clock, synchronous active-high reset, clock enable
//   cra, crin, crwe       control-register address, write data, write strobe
//   crout                 registered, zero-extended read data
//   dma_done/ack/rel      terminal count, request accepted, transfer finished (channel dmach)
//   dma_req, dmach        request flag and requested/serviced channel
//   dma_end               one-cycle end-of-transfer strobe per channel
//   int_stb, int_vec      interrupt source fired and its vector
//   vec_we/sel/din        start-vector write port
module jt900h_cr (
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic [7:0]  cra,
    input  logic [31:0] crin,
    input  logic        crwe,
    output logic [31:0] crout,
    input  logic        dma_done,
    input  logic        dma_ack,
    input  logic        dma_rel,
    output logic        dma_req,
    output logic [1:0]  dmach,
    output logic [3:0]  dma_end,
    input  logic        int_stb,
    input  logic [7:0]  int_vec,
    input  logic        vec_we,
    input  logic [1:0]  vec_sel,
    input  logic [7:0]  vec_din
);

    typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

    state_t state, state_nx;

    logic [3:0][31:0] dmas;
    logic [3:0][31:0] dmad;
    logic [3:0][15:0] dmac;
    logic [3:0][7:0]  dmam;
    logic [15:0]      intnest;

    logic [3:0][7:0]  vec, vec_nx;
    logic [3:0]       pend, pend_nx;
    logic [1:0]       low_idx;
    logic [31:0]      rd_data;

    // Address decode: bits [3:2] pick the channel inside each register group.
    logic [1:0] idx;
    logic       sel_s, sel_d, sel_c, sel_m, sel_n;

    assign idx   = cra[3:2];
    assign sel_s = (cra[7:4] == 4'h0) && (cra[1:0] == 2'b00);
    assign sel_d = (cra[7:4] == 4'h1) && (cra[1:0] == 2'b00);
    assign sel_c = (cra[7:4] == 4'h2) && (cra[1:0] == 2'b00);
    assign sel_m = (cra[7:4] == 4'h2) && (cra[1:0] == 2'b10);
    assign sel_n = (cra == 8'h3C);

    always_comb begin
        rd_data = 32'd0;
        if (sel_s) rd_data = dmas[idx];
        if (sel_d) rd_data = dmad[idx];
        if (sel_c) rd_data = {16'd0, dmac[idx]};
        if (sel_m) rd_data = {24'd0, dmam[idx]};
        if (sel_n) rd_data = {16'd0, intnest};
    end

    // Per-channel pending/vector update. Later statements take priority:
    // a trigger match beats the ack clear, dma_done beats the match,
    // and a vector write beats everything.
    always_comb begin
        pend_nx = pend;
        vec_nx  = vec;
        for (int i = 0; i < 4; i++) begin
            if (int_stb && (int_vec != 8'd0) && (vec[i] == int_vec))
                pend_nx[i] = 1'b1;
            else if ((state == REQ) && dma_ack && (dmach == 2'(i)))
                pend_nx[i] = 1'b0;
            if (dma_done && (dmach == 2'(i))) begin
                pend_nx[i] = 1'b0;
                vec_nx[i]  = 8'd0;
            end
            if (vec_we && (vec_sel == 2'(i))) begin
                pend_nx[i] = 1'b0;
                vec_nx[i]  = vec_din;
            end
        end
    end

    always_comb begin
        low_idx = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (pend[i]) low_idx = 2'(i);
    end

    // A request is withdrawn if its pending bit is gone or is being
    // cleared this cycle, even if the CPU acks at the same time.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (|pend) state_nx = REQ;
            REQ: begin
                if (!pend[dmach] || dma_done || (vec_we && (vec_sel == dmach)))
                    state_nx = IDLE;
                else if (dma_ack)
                    state_nx = SERV;
            end
            SERV: if (dma_rel || dma_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dma_req = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            dmas    <= '0;
            dmad    <= '0;
            dmac    <= '0;
            dmam    <= '0;
            intnest <= 16'd0;
            vec     <= '0;
            pend    <= 4'd0;
            dmach   <= 2'd0;
            dma_end <= 4'd0;
            crout   <= 32'd0;
        end else if (cen) begin
            // Read samples the pre-write contents: no write-to-read bypass.
            crout <= rd_data;
            if (crwe) begin
                if (sel_s) dmas[idx] <= crin;
                if (sel_d) dmad[idx] <= crin;
                if (sel_c) dmac[idx] <= crin[15:0];
                if (sel_m) dmam[idx] <= crin[7:0];
                if (sel_n) intnest   <= crin[15:0];
            end
            state   <= state_nx;
            pend    <= pend_nx;
            vec     <= vec_nx;
            dma_end <= dma_done ? (4'b0001 << dmach) : 4'd0;
            if (state == IDLE && state_nx == REQ)
                dmach <= low_idx;
        end
    end

endmodule

// File: tb/tb_jt900h_cr.sv
// tb/tb_jt900h_cr.sv - self-checking bench for jt900h_cr
module tb_jt900h_cr;

    logic        rst = 1'b1;
    logic        clk = 1'b0;
    logic        cen = 1'b0;
    logic [7:0]  cra = 8'd0;
    logic [31:0] crin = 32'd0;
    logic        crwe = 1'b0;
    logic [31:0] crout;
    logic        dma_done = 1'b0;
    logic        dma_ack = 1'b0;
    logic        dma_rel = 1'b0;
    logic        dma_req;
    logic [1:0]  dmach;
    logic [3:0]  dma_end;
    logic        int_stb = 1'b0;
    logic [7:0]  int_vec = 8'd0;
    logic        vec_we = 1'b0;
    logic [1:0]  vec_sel = 2'd0;
    logic [7:0]  vec_din = 8'd0;

    always #5 clk = ~clk;

    jt900h_cr dut (
        .rst(rst), .clk(clk), .cen(cen),
        .cra(cra), .crin(crin), .crwe(crwe), .crout(crout),
        .dma_done(dma_done), .dma_ack(dma_ack), .dma_rel(dma_rel),
        .dma_req(dma_req), .dmach(dmach), .dma_end(dma_end),
        .int_stb(int_stb), .int_vec(int_vec),
        .vec_we(vec_we), .vec_sel(vec_sel), .vec_din(vec_din)
    );

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit gap = 1'b0;

    // Model state: register file by address, start vectors, pending set,
    // service phase (0 idle, 1 requesting, 2 in service), current channel.
    bit [31:0] m_reg [256];
    bit [31:0] m_crout;
    bit [7:0]  m_vec [4];
    bit [3:0]  m_pend;
    int        m_ph;
    int        m_ch;
    bit [3:0]  m_end;

    function automatic bit [31:0] wmask(input bit [7:0] a);
        if (a < 8'h20 && a[1:0] == 2'd0) return 32'hFFFF_FFFF;
        if (a >= 8'h20 && a < 8'h30 && a[1:0] == 2'd0) return 32'h0000_FFFF;
        if (a >= 8'h20 && a < 8'h30 && a[1:0] == 2'd2) return 32'h0000_00FF;
        if (a == 8'h3C) return 32'h0000_FFFF;
        return 32'd0;
    endfunction

    task automatic model_step();
        bit [7:0] nv [4];
        bit [3:0] np;
        int low;
        if (rst) begin
            foreach (m_reg[k]) m_reg[k] = 32'd0;
            foreach (m_vec[k]) m_vec[k] = 8'd0;
            m_pend = 4'd0; m_ph = 0; m_ch = 0; m_end = 4'd0; m_crout = 32'd0;
            return;
        end
        if (!cen) return;
        m_crout = m_reg[cra];
        if (crwe) m_reg[cra] = crin & wmask(cra);
        m_end = dma_done ? 4'(1 << m_ch) : 4'd0;
        np = m_pend;
        for (int i = 0; i < 4; i++) begin
            nv[i] = m_vec[i];
            if (int_stb && int_vec != 8'd0 && m_vec[i] == int_vec) np[i] = 1'b1;
            else if (m_ph == 1 && dma_ack && m_ch == i) np[i] = 1'b0;
            if (dma_done && m_ch == i) begin np[i] = 1'b0; nv[i] = 8'd0; end
            if (vec_we && int'(vec_sel) == i) begin np[i] = 1'b0; nv[i] = vec_din; end
        end
        case (m_ph)
            0: begin
                low = -1;
                for (int i = 3; i >= 0; i--) if (m_pend[i]) low = i;
                if (low >= 0) begin m_ph = 1; m_ch = low; end
            end
            1: begin
                if (!m_pend[m_ch] || dma_done || (vec_we && int'(vec_sel) == m_ch)) m_ph = 0;
                else if (dma_ack) m_ph = 2;
            end
            default: if (dma_rel || dma_done) m_ph = 0;
        endcase
        m_pend = np;
        for (int i = 0; i < 4; i++) m_vec[i] = nv[i];
    endtask

    always @(posedge clk) model_step();

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("crout", crout, m_crout);
            cmp("dma_req", 32'(dma_req), 32'(m_ph == 1));
            cmp("dmach", 32'(dmach), 32'(m_ch));
            cmp("dma_end", 32'(dma_end), 32'(m_end));
        end
    end

    task automatic tick();
        if (gap) begin
            cen = 1'b0;
            @(negedge clk);
        end
        cen = 1'b1;
        @(negedge clk);
        crwe = 1'b0; int_stb = 1'b0; dma_ack = 1'b0;
        dma_rel = 1'b0; dma_done = 1'b0; vec_we = 1'b0;
    endtask

    task automatic setvec(input logic [1:0] s, input logic [7:0] d);
        vec_we = 1'b1; vec_sel = s; vec_din = d; tick();
    endtask

    task automatic trig(input logic [7:0] v);
        int_stb = 1'b1; int_vec = v; tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cra = a; crin = d; crwe = 1'b1; tick();
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp);
        cra = a; tick();
        cmp("readback", crout, exp);
    endtask

    task automatic scenario();
        // two channels share a vector: lowest index first
        setvec(2'd1, 8'h0A); setvec(2'd3, 8'h0A); trig(8'h0A);
        tick();
        cmp("arb_req", 32'(dma_req), 32'd1);
        cmp("arb_ch1", 32'(dmach), 32'd1);
        dma_ack = 1'b1; tick();
        cmp("ack_drop", 32'(dma_req), 32'd0);
        dma_rel = 1'b1; tick();
        tick();
        cmp("arb_ch3", 32'(dmach), 32'd3);
        cmp("arb_req3", 32'(dma_req), 32'd1);
        dma_ack = 1'b1; tick();
        dma_rel = 1'b1; tick();
        tick();

        // terminal count on channel 2
        setvec(2'd2, 8'h55); trig(8'h55); tick();
        cmp("tc_ch2", 32'(dmach), 32'd2);
        dma_ack = 1'b1; tick();
        dma_done = 1'b1; tick();
        cmp("tc_end", 32'(dma_end), 32'h4);
        tick();
        cmp("tc_end_clr", 32'(dma_end), 32'h0);
        trig(8'h55); tick();
        cmp("tc_norq", 32'(dma_req), 32'd0);

        // trigger collides with ack: channel 0 is requested again
        setvec(2'd0, 8'h21); trig(8'h21); tick();
        cmp("col_ch0", 32'(dmach), 32'd0);
        dma_ack = 1'b1; int_stb = 1'b1; int_vec = 8'h21; tick();
        dma_rel = 1'b1; tick();
        tick();
        cmp("col_rereq", 32'(dma_req), 32'd1);
        dma_ack = 1'b1; tick();
        // done collides with a match: no new request
        dma_done = 1'b1; int_stb = 1'b1; int_vec = 8'h21; tick();
        cmp("col_end", 32'(dma_end), 32'h1);
        tick(); tick();
        cmp("col_norq", 32'(dma_req), 32'd0);

        // vector write collides with done: new vector kept
        setvec(2'd0, 8'h30); trig(8'h30); tick();
        dma_ack = 1'b1; tick();
        dma_done = 1'b1; vec_we = 1'b1; vec_sel = 2'd0; vec_din = 8'h77; tick();
        tick();
        cmp("vd_norq", 32'(dma_req), 32'd0);
        trig(8'h77); tick();
        cmp("vd_req", 32'(dma_req), 32'd1);
        cmp("vd_ch0", 32'(dmach), 32'd0);
        dma_ack = 1'b1; tick();
        dma_rel = 1'b1; tick();

        // vector write cancels a pending request
        setvec(2'd1, 8'h33); trig(8'h33); tick();
        cmp("can_req", 32'(dma_req), 32'd1);
        setvec(2'd1, 8'h44);
        cmp("can_drop", 32'(dma_req), 32'd0);
        tick();
        cmp("can_idle", 32'(dma_req), 32'd0);
        trig(8'h44); tick();
        cmp("can_newvec", 32'(dma_req), 32'd1);
        cmp("can_ch1", 32'(dmach), 32'd1);
        dma_ack = 1'b1; tick();
        dma_rel = 1'b1; tick();
        tick();
    endtask

    initial begin
        tick(); tick();
        rst = 1'b0;
        cmp_en = 1'b1;
        cmp("rst_crout", crout, 32'd0);
        cmp("rst_req", 32'(dma_req), 32'd0);

        for (int a = 0; a < 256; a++) begin
            cra = 8'(a); tick();
        end

        wr(8'h04, 32'hDEADBEEF); rd(8'h04, 32'hDEADBEEF);
        wr(8'h20, 32'hDEADBEEF); rd(8'h20, 32'h0000BEEF);
        wr(8'h22, 32'hDEADBEEF); rd(8'h22, 32'h000000EF);
        wr(8'h3C, 32'hDEADBEEF); rd(8'h3C, 32'h0000BEEF);
        wr(8'h3D, 32'h12345678); rd(8'h3D, 32'h0);
        rd(8'h00, 32'h0);
        rd(8'h24, 32'h0);
        for (int a = 0; a < 64; a++) begin
            cra = 8'(a); tick();
        end

        gap = 1'b0;
        scenario();
        gap = 1'b1;
        scenario();
        gap = 1'b0;

        // reset while in service: everything clears, no end strobe
        setvec(2'd2, 8'h66); trig(8'h66); tick();
        dma_ack = 1'b1; tick();
        cra = 8'h04;
        rst = 1'b1; dma_done = 1'b1; tick();
        cmp("rs_end", 32'(dma_end), 32'h0);
        cmp("rs_req", 32'(dma_req), 32'd0);
        cmp("rs_ch", 32'(dmach), 32'd0);
        cmp("rs_crout", crout, 32'd0);
        rst = 1'b0; tick();
        cmp("rs_end2", 32'(dma_end), 32'h0);
        rd(8'h04, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
